// File: rtl/gshare_btb_predictor.sv
// Branch-direction predictor (bimodal / gshare / concat indexed PHT of saturating
// counters) fused with a direct-mapped BTB, trained non-speculatively at execute.
module gshare_btb_predictor #(
  parameter int PHT_BITS  = 8,
  parameter int HIST_BITS = 8,
  parameter int CTR_BITS  = 2,
  parameter int BTB_BITS  = 4,
  parameter int MODE      = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [31:0]          PC_current,
  output logic [31:0]          PCPredict,
  output logic                 prediction,
  output logic                 btbhit,
  input  logic [31:0]          PC,
  input  logic [31:0]          PCBranch,
  input  logic                 Branch,
  input  logic                 BranchTaken,
  input  logic                 PredictedE,
  output logic [HIST_BITS-1:0] ghr_out,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
);

  localparam int PHT_DEPTH = 1 << PHT_BITS;
  localparam int BTB_DEPTH = 1 << BTB_BITS;
  localparam int TAG_BITS  = 30 - BTB_BITS;
  localparam int LOW_BITS  = PHT_BITS - HIST_BITS;
  localparam logic [PHT_BITS-1:0] LOW_MASK = PHT_BITS'((1 << LOW_BITS) - 1);
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  generate
    if (HIST_BITS < 1 || HIST_BITS > PHT_BITS) begin : g_bad_hist
      $error("gshare_btb_predictor: HIST_BITS must be within 1..PHT_BITS");
    end
    if (CTR_BITS < 2 || CTR_BITS > 4) begin : g_bad_ctr
      $error("gshare_btb_predictor: CTR_BITS must be within 2..4");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("gshare_btb_predictor: MODE must be 0, 1 or 2");
    end
  endgenerate

  // In concat mode the history occupies the upper index bits; with full-length
  // history LOW_MASK is zero and the index degenerates to the GHR alone.
  function automatic logic [PHT_BITS-1:0] pht_index(input logic [31:0] addr,
                                                     input logic [HIST_BITS-1:0] hist);
    logic [PHT_BITS-1:0] w;
    logic [PHT_BITS-1:0] g;
    w = addr[PHT_BITS+1:2];
    g = PHT_BITS'(hist);
    case (MODE)
      0:       return w;
      1:       return w ^ g;
      default: return (g << LOW_BITS) | (w & LOW_MASK);
    endcase
  endfunction

  logic [CTR_BITS-1:0] pht_q     [PHT_DEPTH];
  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [TAG_BITS-1:0] btb_tag_q [BTB_DEPTH];
  logic [31:0]         btb_tgt_q [BTB_DEPTH];
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         branch_cnt_q, branch_cnt_d;
  logic [31:0]         mispred_cnt_q, mispred_cnt_d;

  logic [PHT_BITS-1:0] lk_pht_idx, up_pht_idx;
  logic [BTB_BITS-1:0] lk_btb_idx, up_btb_idx;
  logic                lk_hit;
  logic [CTR_BITS-1:0] up_ctr, up_ctr_d;

  // Fetch lookup: purely combinational on committed state, no update bypass.
  always_comb begin
    lk_pht_idx = pht_index(PC_current, ghr_q);
    lk_btb_idx = PC_current[BTB_BITS+1:2];
    lk_hit     = btb_valid_q[lk_btb_idx] &&
                 (btb_tag_q[lk_btb_idx] == PC_current[31:BTB_BITS+2]);
    prediction = lk_hit && pht_q[lk_pht_idx][CTR_BITS-1];
    btbhit     = prediction;
    PCPredict  = lk_hit ? btb_tgt_q[lk_btb_idx] : 32'd0;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    up_pht_idx    = pht_index(PC, ghr_q);
    up_btb_idx    = PC[BTB_BITS+1:2];
    up_ctr        = pht_q[up_pht_idx];
    up_ctr_d      = up_ctr;
    ghr_d         = ghr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (BranchTaken) begin
      if (up_ctr != CTR_MAX) up_ctr_d = up_ctr + 1'b1;
    end else begin
      if (up_ctr != '0) up_ctr_d = up_ctr - 1'b1;
    end
    if (Branch) begin
      ghr_d = HIST_BITS'({ghr_q, BranchTaken});
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 32'd1;
      if (BranchTaken != PredictedE && mispred_cnt_q != '1)
        mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CTR_INIT;
      btb_valid_q   <= '0;
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (Branch) begin
        pht_q[up_pht_idx] <= up_ctr_d;
        if (BranchTaken) btb_valid_q[up_btb_idx] <= 1'b1;
      end
      ghr_q         <= ghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // NOTE: BTB tag/target storage is not reset; the valid bits alone gate its
  // contents, so only they need clearing.
  always_ff @(posedge Clk) begin
    if (!Rst && Branch && BranchTaken) begin
      btb_tag_q[up_btb_idx] <= PC[31:BTB_BITS+2];
      btb_tgt_q[up_btb_idx] <= PCBranch;
    end
  end

  assign ghr_out          = ghr_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench: three predictor configurations (bimodal, gshare, concat)
// share one stimulus stream and are compared every cycle against a table model.
module tb_gshare_btb_predictor;

  logic        Clk = 1'b0;
  logic        Rst, Branch, BranchTaken, PredictedE;
  logic [31:0] PC_current, PC, PCBranch;

  logic [31:0] o_pcp [3];
  logic [31:0] o_bc  [3];
  logic [31:0] o_mc  [3];
  logic        o_pred[3];
  logic        o_hit [3];
  logic [7:0]  ghr0;
  logic [1:0]  ghr1;
  logic [2:0]  ghr2;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  gshare_btb_predictor #(.PHT_BITS(8), .HIST_BITS(8), .CTR_BITS(2), .BTB_BITS(4), .MODE(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .PC_current(PC_current), .PCPredict(o_pcp[0]),
    .prediction(o_pred[0]), .btbhit(o_hit[0]), .PC(PC), .PCBranch(PCBranch),
    .Branch(Branch), .BranchTaken(BranchTaken), .PredictedE(PredictedE),
    .ghr_out(ghr0), .branch_count(o_bc[0]), .mispredict_count(o_mc[0]));

  gshare_btb_predictor #(.PHT_BITS(8), .HIST_BITS(2), .CTR_BITS(2), .BTB_BITS(4), .MODE(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .PC_current(PC_current), .PCPredict(o_pcp[1]),
    .prediction(o_pred[1]), .btbhit(o_hit[1]), .PC(PC), .PCBranch(PCBranch),
    .Branch(Branch), .BranchTaken(BranchTaken), .PredictedE(PredictedE),
    .ghr_out(ghr1), .branch_count(o_bc[1]), .mispredict_count(o_mc[1]));

  gshare_btb_predictor #(.PHT_BITS(8), .HIST_BITS(3), .CTR_BITS(3), .BTB_BITS(4), .MODE(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .PC_current(PC_current), .PCPredict(o_pcp[2]),
    .prediction(o_pred[2]), .btbhit(o_hit[2]), .PC(PC), .PCBranch(PCBranch),
    .Branch(Branch), .BranchTaken(BranchTaken), .PredictedE(PredictedE),
    .ghr_out(ghr2), .branch_count(o_bc[2]), .mispredict_count(o_mc[2]));

  // Reference model: plain tables updated by the architectural rules.
  int unsigned m_pht[3][256];
  bit          m_bv [3][16];
  logic [31:0] m_tag[3][16];
  logic [31:0] m_tgt[3][16];
  int unsigned m_ghr[3];
  logic [31:0] m_bc, m_mc;

  function automatic int hist_of(input int d);
    case (d)
      0: return 8;
      1: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int ctr_of(input int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic logic [31:0] got_ghr(input int d);
    case (d)
      0: return {24'd0, ghr0};
      1: return {30'd0, ghr1};
      default: return {29'd0, ghr2};
    endcase
  endfunction

  function automatic int m_idx(input int d, input logic [31:0] a);
    int w, g, lb;
    w = int'((a >> 2) % 256);
    g = int'(m_ghr[d]);
    case (d)
      0: return w;
      1: return w ^ g;
      default: begin
        lb = 8 - hist_of(d);
        return g * (2 ** lb) + (w % (2 ** lb));
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 256; i++) m_pht[d][i] = (2 ** (ctr_of(d) - 1)) - 1;
      for (int i = 0; i < 16; i++) m_bv[d][i] = 1'b0;
      m_ghr[d] = 0;
    end
    m_bc = 32'd0;
    m_mc = 32'd0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt,
                              input bit tk, input bit pe);
    int i, bi;
    for (int d = 0; d < 3; d++) begin
      i  = m_idx(d, pc);
      bi = int'((pc >> 2) % 16);
      if (tk && m_pht[d][i] < (2 ** ctr_of(d)) - 1) m_pht[d][i]++;
      if (!tk && m_pht[d][i] > 0) m_pht[d][i]--;
      if (tk) begin
        m_bv[d][bi]  = 1'b1;
        m_tag[d][bi] = pc >> 6;
        m_tgt[d][bi] = tgt;
      end
      m_ghr[d] = (m_ghr[d] * 2 + (tk ? 1 : 0)) % (2 ** hist_of(d));
    end
    if (m_bc != 32'hFFFF_FFFF) m_bc++;
    if (tk != pe && m_mc != 32'hFFFF_FFFF) m_mc++;
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, got, exp);
    end
  endtask

  task automatic check_all(input logic [31:0] pcc);
    int bi;
    bit hit, pred;
    logic [31:0] pcp;
    for (int d = 0; d < 3; d++) begin
      bi   = int'((pcc >> 2) % 16);
      hit  = m_bv[d][bi] && (m_tag[d][bi] == (pcc >> 6));
      pred = hit && (m_pht[d][m_idx(d, pcc)] >= 2 ** (ctr_of(d) - 1));
      pcp  = hit ? m_tgt[d][bi] : 32'd0;
      chk("prediction", d, {31'd0, o_pred[d]}, {31'd0, pred});
      chk("btbhit", d, {31'd0, o_hit[d]}, {31'd0, pred});
      chk("PCPredict", d, o_pcp[d], pcp);
      chk("ghr_out", d, got_ghr(d), m_ghr[d]);
      chk("branch_count", d, o_bc[d], m_bc);
      chk("mispredict_count", d, o_mc[d], m_mc);
    end
  endtask

  // One cycle: drive inputs, check lookup at the falling edge, then advance.
  task automatic step(input bit rst, input bit br, input logic [31:0] pc,
                      input logic [31:0] tgt, input bit tk, input bit pe,
                      input logic [31:0] pcc);
    Rst = rst; Branch = br; PC = pc; PCBranch = tgt;
    BranchTaken = tk; PredictedE = pe; PC_current = pcc;
    @(negedge Clk);
    check_all(pcc);
    @(posedge Clk);
    if (rst) model_reset();
    else if (br) model_update(pc, tgt, tk, pe);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 31)) << 2);
  endfunction

  initial begin
    logic [31:0] rpc, rtgt;
    Rst = 1'b1; Branch = 1'b0; BranchTaken = 1'b0; PredictedE = 1'b0;
    PC = 32'd0; PCBranch = 32'd0; PC_current = 32'd0;
    @(posedge Clk);
    #1;
    model_reset();

    // Reset sweep, with junk on the ignored update inputs.
    for (int i = 0; i < 256; i++)
      step(0, 0, $urandom, $urandom, 1'($urandom), 1'($urandom), 32'(i) << 2);

    // BTB training at 0x40, then one not-taken update.
    step(0, 1, 32'h40, 32'h80, 1, 0, 32'h40);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h40);
    step(0, 1, 32'h40, 32'h80, 0, 1, 32'h40);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h40);

    // Saturation and perf counters at 0x100.
    step(1, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h100, 32'h180, 1, 1, 32'h100);
    step(0, 1, 32'h100, 32'h180, 0, 1, 32'h100);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h100);

    // Alias in the direct-mapped BTB.
    step(0, 1, 32'h40, 32'h80, 1, 1, 32'h40);
    step(0, 1, 32'h80, 32'hC0, 1, 1, 32'h40);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h40);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h80);

    // Alternating pattern at 0x200, then lookups under the learned history.
    step(1, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'h200, 32'h240, (i % 2) == 0, 1, 32'h200);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h200, 32'h240, (i % 2) == 0, 1, 32'h200);
      step(0, 0, 32'h0, 32'h0, 0, 0, 32'h200);
    end

    // Same-cycle update/lookup hazard, then reset with a branch pending.
    step(0, 1, 32'h300, 32'h340, 1, 0, 32'h300);
    step(0, 1, 32'h300, 32'h340, 1, 0, 32'h300);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h300);
    step(1, 1, 32'h300, 32'h340, 1, 0, 32'h300);
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h300);

    // Randomized traffic over a small aliasing address pool.
    for (int n = 0; n < 800; n++) begin
      rpc  = rand_pc();
      rtgt = $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rpc, rtgt,
           $urandom_range(0, 2) != 0, 1'($urandom),
           $urandom_range(0, 1) != 0 ? rpc : rand_pc());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
